// File: rtl/mpu_bus_sync.sv
// MPU bus front-end: synchronizes the asynchronous active-low MPU strobes into clk
// and turns each MPU access into exactly one qualified core read or write.
module mpu_bus_sync #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  _mpu_en,
  input  logic                  _mpu_rd,
  input  logic                  _mpu_wr,
  input  logic [1:0]            _mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr_in,
  input  logic [DATA_WIDTH-1:0] mpu_data_in,
  output logic [DATA_WIDTH-1:0] mpu_data_out,
  output logic                  mpu_ready,
  output logic                  core_rd,
  output logic                  core_wr,
  output logic [1:0]            core_be,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_ready
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, HOLD} state_e;

  state_e                state_q, state_d;
  logic [2:0]            sync1_q, sync2_q;
  logic                  coreRd_q, coreRd_d;
  logic                  coreWr_q, coreWr_d;
  logic                  mpuReady_q, mpuReady_d;
  logic [1:0]            coreBe_q, coreBe_d;
  logic [ADDR_WIDTH-1:0] coreAddr_q, coreAddr_d;
  logic [DATA_WIDTH-1:0] coreData_q, coreData_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic enS, rdS, wrS;
  logic reqRd, reqWr, reqBad, released;

  // Two-flop synchronizers for {en, rd, wr}; they idle at the inactive level (1).
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= {_mpu_en, _mpu_rd, _mpu_wr};
      sync2_q <= sync1_q;
    end
  end

  assign {enS, rdS, wrS} = sync2_q;
  assign reqRd    = ~enS & ~rdS &  wrS;
  assign reqWr    = ~enS & ~wrS &  rdS;
  assign reqBad   = ~enS & ~rdS & ~wrS;
  assign released =  enS &  rdS &  wrS;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= IDLE;
      coreRd_q   <= 1'b0;
      coreWr_q   <= 1'b0;
      mpuReady_q <= 1'b0;
      coreBe_q   <= '0;
      coreAddr_q <= '0;
      coreData_q <= '0;
      rdData_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      coreRd_q   <= coreRd_d;
      coreWr_q   <= coreWr_d;
      mpuReady_q <= mpuReady_d;
      coreBe_q   <= coreBe_d;
      coreAddr_q <= coreAddr_d;
      coreData_q <= coreData_d;
      rdData_q   <= rdData_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coreRd_d   = coreRd_q;
    coreWr_d   = coreWr_q;
    mpuReady_d = mpuReady_q;
    coreBe_d   = coreBe_q;
    coreAddr_d = coreAddr_q;
    coreData_d = coreData_q;
    rdData_d   = rdData_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (reqRd || reqWr) begin
          coreAddr_d = mpu_addr_in;
          coreData_d = mpu_data_in;
          coreBe_d   = ~_mpu_be;
          coreRd_d   = reqRd;
          coreWr_d   = reqWr;
          state_d    = ISSUE;
        end else if (reqBad) begin
          mpuReady_d = 1'b1;
          state_d    = HOLD;
        end
      end
      ISSUE: begin
        // The request is committed once accepted, even if the MPU already let go.
        if (core_ready) begin
          coreRd_d = 1'b0;
          coreWr_d = 1'b0;
          if (coreWr_q) begin
            mpuReady_d = 1'b1;
            state_d    = HOLD;
          end else begin
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdData_d   = core_data_in;
          mpuReady_d = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (released) begin
          mpuReady_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mpu_data_out  = rdData_q;
  assign mpu_ready     = mpuReady_q;
  assign core_rd       = coreRd_q;
  assign core_wr       = coreWr_q;
  assign core_be       = coreBe_q;
  assign core_addr     = coreAddr_q;
  assign core_data_out = coreData_q;

endmodule

// File: tb/tb_mpu_bus_sync.sv
// Directed bench for mpu_bus_sync with READ_LATENCY=2; a tiny core model returns
// read data only in the cycle the DUT is expected to capture it.
module tb_mpu_bus_sync;

  logic        clk = 1'b0;
  logic        resetN;
  logic        mpuEnN, mpuRdN, mpuWrN;
  logic [1:0]  mpuBeN;
  logic [15:0] mpuAddr, mpuDataIn, mpuDataOut;
  logic        mpuReady;
  logic        coreRd, coreWr;
  logic [1:0]  coreBe;
  logic [15:0] coreAddr, coreDataOut;
  logic [15:0] coreDataIn = 16'hDEAD;
  logic        coreReady;

  int passCount  = 0;
  int checkCount = 0;
  int wrCycles = 0, wrPulses = 0, rdPulses = 0;
  logic wrPrev = 1'b0, rdPrev = 1'b0;
  int phase = 0;
  logic [15:0] rdData = 16'h0000;

  mpu_bus_sync #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(2)) dut (
    .clk(clk), ._reset(resetN),
    ._mpu_en(mpuEnN), ._mpu_rd(mpuRdN), ._mpu_wr(mpuWrN), ._mpu_be(mpuBeN),
    .mpu_addr_in(mpuAddr), .mpu_data_in(mpuDataIn),
    .mpu_data_out(mpuDataOut), .mpu_ready(mpuReady),
    .core_rd(coreRd), .core_wr(coreWr), .core_be(coreBe),
    .core_addr(coreAddr), .core_data_out(coreDataOut),
    .core_data_in(coreDataIn), .core_ready(coreReady)
  );

  always #5 clk = ~clk;

  // Request monitor plus core model: data is valid only around the edge two cycles after accept.
  always @(negedge clk) begin
    if (coreWr) wrCycles++;
    if (coreWr && !wrPrev) wrPulses++;
    if (coreRd && !rdPrev) rdPulses++;
    wrPrev = coreWr;
    rdPrev = coreRd;
    if (phase == 0 && coreRd && coreReady) phase = 1;
    else if (phase == 1) phase = 2;
    else if (phase == 2) begin coreDataIn = rdData; phase = 3; end
    else if (phase == 3) begin coreDataIn = 16'hDEAD; phase = 0; end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic rd, input logic wr, input logic [1:0] be,
                               input logic [15:0] addr, input logic [15:0] data);
    mpuEnN = en; mpuRdN = rd; mpuWrN = wr; mpuBeN = be;
    mpuAddr = addr; mpuDataIn = data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic releaseStrobes();
    mpuEnN = 1'b1; mpuRdN = 1'b1; mpuWrN = 1'b1;
  endtask

  task automatic clearCounts();
    wrCycles = 0; wrPulses = 0; rdPulses = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetN = 1'b0; coreReady = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 16'h0000, 16'h0000);
    tick(2);
    checkOutput("rst_core_wr", coreWr, 0);
    checkOutput("rst_core_rd", coreRd, 0);
    checkOutput("rst_ready", mpuReady, 0);
    checkOutput("rst_addr", coreAddr, 0);
    resetN = 1'b1;
    tick(1);

    // Plain write, core always ready.
    clearCounts();
    coreReady = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 16'h0123, 16'hBEEF);
    tick(2);
    checkOutput("wr_not_yet", coreWr, 0);
    tick(1);
    checkOutput("wr_issue", coreWr, 1);
    checkOutput("wr_addr", coreAddr, 16'h0123);
    checkOutput("wr_data", coreDataOut, 16'hBEEF);
    checkOutput("wr_be", coreBe, 2'b11);
    checkOutput("wr_ready_lo", mpuReady, 0);
    tick(1);
    checkOutput("wr_done", coreWr, 0);
    checkOutput("wr_ready_hi", mpuReady, 1);
    releaseStrobes();
    tick(2);
    checkOutput("wr_ready_hold", mpuReady, 1);
    tick(1);
    checkOutput("wr_ready_fall", mpuReady, 0);
    checkOutput("wr_cycles", wrCycles, 1);
    checkOutput("wr_no_read", rdPulses, 0);

    // Read with two-cycle core latency.
    clearCounts();
    rdData = 16'h5A5A;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 16'h0200, 16'h0000);
    tick(3);
    checkOutput("rd_issue", coreRd, 1);
    checkOutput("rd_addr", coreAddr, 16'h0200);
    tick(2);
    checkOutput("rd_wait_ready", mpuReady, 0);
    checkOutput("rd_wait_data", mpuDataOut, 16'h0000);
    tick(1);
    checkOutput("rd_ready", mpuReady, 1);
    checkOutput("rd_data", mpuDataOut, 16'h5A5A);
    checkOutput("rd_pulses", rdPulses, 1);
    releaseStrobes();
    tick(3);
    checkOutput("rd_ready_fall", mpuReady, 0);
    checkOutput("rd_data_held", mpuDataOut, 16'h5A5A);

    // Write stalled by core_ready low for five cycles.
    clearCounts();
    coreReady = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 16'h0444, 16'h1111);
    tick(3);
    checkOutput("st_issue", coreWr, 1);
    checkOutput("st_be", coreBe, 2'b01);
    tick(5);
    checkOutput("st_held", coreWr, 1);
    checkOutput("st_ready_lo", mpuReady, 0);
    coreReady = 1'b1;
    tick(1);
    checkOutput("st_done", coreWr, 0);
    checkOutput("st_ready_hi", mpuReady, 1);
    checkOutput("st_cycles", wrCycles, 6);
    checkOutput("st_pulses", wrPulses, 1);
    releaseStrobes();
    tick(3);
    checkOutput("st_ready_fall", mpuReady, 0);

    // Read and write strobes both low: acknowledged without a core access.
    clearCounts();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 16'h0666, 16'h3333);
    tick(3);
    checkOutput("bad_ready", mpuReady, 1);
    checkOutput("bad_no_wr", coreWr, 0);
    checkOutput("bad_no_rd", coreRd, 0);
    releaseStrobes();
    tick(3);
    checkOutput("bad_ready_fall", mpuReady, 0);
    checkOutput("bad_no_access", wrPulses + rdPulses, 0);

    // Write strobe released while the request is still stalled in ISSUE.
    clearCounts();
    coreReady = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 16'h0555, 16'h2222);
    tick(3);
    checkOutput("er_issue", coreWr, 1);
    releaseStrobes();
    tick(2);
    checkOutput("er_still_held", coreWr, 1);
    coreReady = 1'b1;
    tick(1);
    checkOutput("er_done", coreWr, 0);
    checkOutput("er_ready_pulse", mpuReady, 1);
    tick(1);
    checkOutput("er_ready_fall", mpuReady, 0);
    tick(4);
    checkOutput("er_one_write", wrPulses, 1);
    checkOutput("er_cycles", wrCycles, 3);
    checkOutput("er_data", coreDataOut, 16'h2222);

    // Asynchronous reset in the middle of a read, then a fresh read.
    clearCounts();
    rdData = 16'h7777;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 16'h0300, 16'h0000);
    tick(3);
    checkOutput("rr_issue", coreRd, 1);
    tick(1);
    #1 resetN = 1'b0;
    #1;
    checkOutput("rr_rd", coreRd, 0);
    checkOutput("rr_ready", mpuReady, 0);
    checkOutput("rr_data_out", mpuDataOut, 0);
    checkOutput("rr_addr", coreAddr, 0);
    checkOutput("rr_be", coreBe, 0);
    releaseStrobes();
    tick(3);
    resetN = 1'b1;
    tick(1);
    clearCounts();
    rdData = 16'h1234;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 16'h0001, 16'h0000);
    tick(3);
    checkOutput("rr2_issue", coreRd, 1);
    checkOutput("rr2_addr", coreAddr, 16'h0001);
    tick(3);
    checkOutput("rr2_ready", mpuReady, 1);
    checkOutput("rr2_data", mpuDataOut, 16'h1234);
    releaseStrobes();
    tick(3);
    checkOutput("rr2_ready_fall", mpuReady, 0);
    checkOutput("rr2_one_read", rdPulses, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
